// File: rtl/multi_spikecnt.sv
// multi_spikecnt: multi-channel windowed spike counter.
//
// Each asynchronous spike line is synchronised into clk1, rising edges are
// counted per channel (saturating, with an optional refractory gap), and at
// every enabled window_tick all running counts are latched at once, a
// one-cycle valid is raised and the window id advances.
//
// Optional feature: define SPKCNT_DIFF_EN to add diff_out, the signed
// difference of each even/odd channel pair, latched together with the counts.
module multi_spikecnt #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_GAP     = 0,
  parameter int unsigned SEL_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                             clk1,
  input  logic                             reset_n,
  input  logic [NCH-1:0]                   spike_in,
  input  logic                             enable,
  input  logic                             window_tick,
  input  logic [SEL_W-1:0]                 rd_sel,
  output logic [CNT_W-1:0]                 cnt_out,
  output logic [NCH*CNT_W-1:0]             cnt_all,
  output logic [NCH-1:0]                   ovf,
  output logic                             valid,
`ifdef SPKCNT_DIFF_EN
  output logic [(NCH/2)*(CNT_W+1)-1:0]     diff_out,
`endif
  output logic [15:0]                      win_id
);

  // Refractory counter only needs to hold MIN_GAP; keep at least one bit.
  localparam int unsigned GapW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [GapW-1:0]  GapLoad = GapW'(MIN_GAP);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  // Synchroniser chain and edge-detect history
  logic [NCH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [NCH-1:0]                  prev_q, prev_d;

  // Running window state
  logic [NCH-1:0][CNT_W-1:0]       run_q, run_d;
  logic [NCH-1:0]                  run_ovf_q, run_ovf_d;
  logic [NCH-1:0][GapW-1:0]        gap_q, gap_d;

  // Latched window results
  logic [NCH-1:0][CNT_W-1:0]       lat_q, lat_d;
  logic [NCH-1:0]                  ovf_q, ovf_d;
  logic                            valid_q, valid_d;
  logic [15:0]                     win_q, win_d;
  logic [CNT_W-1:0]                cnt_out_q, cnt_out_d;

  // Per-cycle decode
  logic                            close;
  logic [NCH-1:0]                  edge_det;
  logic [NCH-1:0]                  counted;
  logic [NCH-1:0]                  sat;
  logic [NCH-1:0][CNT_W-1:0]       run_inc;

  // A window closes only while counting is enabled.
  assign close = window_tick & enable;

  // Synchroniser shift, edge detection, counting and refractory gap per channel
  always_comb begin
    sync_d   = sync_q;
    prev_d   = prev_q;
    edge_det = '0;
    counted  = '0;
    sat      = '0;
    run_inc  = run_q;
    gap_d    = gap_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      sync_d[i]   = {sync_q[i][SYNC_STAGES-2:0], spike_in[i]};
      prev_d[i]   = sync_q[i][SYNC_STAGES-1];
      edge_det[i] = sync_q[i][SYNC_STAGES-1] & ~prev_q[i];
      // Edges inside the refractory gap are dropped and do not re-arm it.
      counted[i]  = edge_det[i] & enable & (gap_q[i] == '0);
      // An edge arriving at full scale is lost; that is what flags overflow.
      sat[i]      = counted[i] & (run_q[i] == CntMax);
      if (counted[i] && !sat[i]) begin
        run_inc[i] = run_q[i] + CNT_W'(1);
      end
      // The gap timer keeps running even while enable is low.
      if (counted[i]) begin
        gap_d[i] = GapLoad;
      end else if (gap_q[i] != '0) begin
        gap_d[i] = gap_q[i] - GapW'(1);
      end
    end
  end

  // Window close: latch counts including this cycle's edge, then restart
  always_comb begin
    run_d     = run_inc;
    run_ovf_d = run_ovf_q | sat;
    lat_d     = lat_q;
    ovf_d     = ovf_q;
    win_d     = win_q;
    valid_d   = close;
    if (close) begin
      lat_d     = run_inc;
      ovf_d     = run_ovf_q | sat;
      run_d     = '0;
      run_ovf_d = '0;
      win_d     = win_q + 16'd1;
    end
  end

  // Registered readout mux; out-of-range selects read as zero
  always_comb begin
    cnt_out_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        cnt_out_d = lat_q[i];
      end
    end
  end

  // State registers
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      prev_q    <= '0;
      run_q     <= '0;
      run_ovf_q <= '0;
      gap_q     <= '0;
      lat_q     <= '0;
      ovf_q     <= '0;
      valid_q   <= 1'b0;
      win_q     <= '0;
      cnt_out_q <= '0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      run_q     <= run_d;
      run_ovf_q <= run_ovf_d;
      gap_q     <= gap_d;
      lat_q     <= lat_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      win_q     <= win_d;
      cnt_out_q <= cnt_out_d;
    end
  end

`ifdef SPKCNT_DIFF_EN
  if ((NCH % 2) != 0) begin : g_nch_odd
    $error("multi_spikecnt: NCH must be even when SPKCNT_DIFF_EN is defined");
  end

  logic [NCH/2-1:0][CNT_W:0] diff_q, diff_d;

  // Agonist minus antagonist per pair, captured on the same edge as lat
  always_comb begin
    diff_d = diff_q;
    if (close) begin
      for (int unsigned k = 0; k < NCH / 2; k++) begin
        diff_d[k] = {1'b0, lat_d[2*k]} - {1'b0, lat_d[2*k+1]};
      end
    end
  end

  // Pair difference register
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      diff_q <= '0;
    end else begin
      diff_q <= diff_d;
    end
  end

  assign diff_out = diff_q;
`endif

  assign cnt_all = lat_q;
  assign ovf     = ovf_q;
  assign valid   = valid_q;
  assign win_id  = win_q;
  assign cnt_out = cnt_out_q;

endmodule

// File: tb/tb_multi_spikecnt.sv
// Testbench for multi_spikecnt: two configurations driven by the same
// stimulus, compared every cycle against a time-based reference model.
module tb_multi_spikecnt;

  logic        clk1 = 1'b0;
  logic        reset_n;
  logic [3:0]  spike;
  logic        enable;
  logic        window_tick;
  logic [2:0]  rd_sel;

  // Instance A: wide counters, no refractory gap, 2-stage synchroniser
  logic [31:0]  a_cnt_out;
  logic [127:0] a_cnt_all;
  logic [3:0]   a_ovf;
  logic         a_valid;
  logic [15:0]  a_win_id;
  // Instance B: 4-bit counters, 10-cycle refractory gap, 3-stage synchroniser
  logic [3:0]   b_cnt_out;
  logic [15:0]  b_cnt_all;
  logic [3:0]   b_ovf;
  logic         b_valid;
  logic [15:0]  b_win_id;
`ifdef SPKCNT_DIFF_EN
  logic [65:0]  a_diff;
  logic [9:0]   b_diff;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk1 = ~clk1;

  multi_spikecnt #(
    .NCH(4), .CNT_W(32), .SYNC_STAGES(2), .MIN_GAP(0), .SEL_W(3)
  ) u_a (
    .clk1(clk1), .reset_n(reset_n), .spike_in(spike), .enable(enable),
    .window_tick(window_tick), .rd_sel(rd_sel), .cnt_out(a_cnt_out),
    .cnt_all(a_cnt_all), .ovf(a_ovf), .valid(a_valid),
`ifdef SPKCNT_DIFF_EN
    .diff_out(a_diff),
`endif
    .win_id(a_win_id)
  );

  multi_spikecnt #(
    .NCH(4), .CNT_W(4), .SYNC_STAGES(3), .MIN_GAP(10), .SEL_W(3)
  ) u_b (
    .clk1(clk1), .reset_n(reset_n), .spike_in(spike), .enable(enable),
    .window_tick(window_tick), .rd_sel(rd_sel), .cnt_out(b_cnt_out),
    .cnt_all(b_cnt_all), .ovf(b_ovf), .valid(b_valid),
`ifdef SPKCNT_DIFF_EN
    .diff_out(b_diff),
`endif
    .win_id(b_win_id)
  );

  // Reference model: input samples since reset, last counted edge time per channel
  logic [3:0] hist[$];
  longint     m_run [2][4];
  longint     m_lat [2][4];
  longint     m_last[2][4];
  bit         m_rovf[2][4];
  bit         m_ovf [2][4];
  bit [15:0]  m_win [2];
  bit         m_valid[2];
  longint     m_cout[2];

  function automatic bit hbit(input int t, input int ch);
    if (t < 0) return 1'b0;
    return hist[t][ch];
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < 2; k++) begin
      for (int ch = 0; ch < 4; ch++) begin
        m_run[k][ch]  = 0;
        m_lat[k][ch]  = 0;
        m_last[k][ch] = -1000;
        m_rovf[k][ch] = 1'b0;
        m_ovf[k][ch]  = 1'b0;
      end
      m_win[k]   = '0;
      m_valid[k] = 1'b0;
      m_cout[k]  = 0;
    end
  endtask

  // One rising clock edge: an input first sampled high at edge n-S and low at
  // n-S-1 is a detected edge at edge n; it counts if enabled and more than
  // MIN_GAP edges have passed since the last counted one.
  task automatic model_edge(input logic [3:0] sp, input logic en, input logic tk,
                            input logic [2:0] sel);
    int     n;
    int     s;
    int     g;
    int     idx;
    longint mx;
    bit     det;
    hist.push_back(sp);
    n = hist.size() - 1;
    idx = int'(sel);
    for (int k = 0; k < 2; k++) begin
      s  = (k == 0) ? 2 : 3;
      g  = (k == 0) ? 0 : 10;
      mx = (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'd15;
      m_cout[k] = (idx < 4) ? m_lat[k][idx] : 0;
      for (int ch = 0; ch < 4; ch++) begin
        det = hbit(n - s, ch) && !hbit(n - s - 1, ch);
        if (det && en && (longint'(n) - m_last[k][ch] > g)) begin
          m_last[k][ch] = n;
          if (m_run[k][ch] == mx) m_rovf[k][ch] = 1'b1;
          else m_run[k][ch] = m_run[k][ch] + 1;
        end
      end
      if (en && tk) begin
        for (int ch = 0; ch < 4; ch++) begin
          m_lat[k][ch]  = m_run[k][ch];
          m_ovf[k][ch]  = m_rovf[k][ch];
          m_run[k][ch]  = 0;
          m_rovf[k][ch] = 1'b0;
        end
        m_win[k] = m_win[k] + 16'd1;
      end
      m_valid[k] = en && tk;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [127:0] ea;
    logic [15:0]  eb;
    logic [3:0]   eoa;
    logic [3:0]   eob;
    for (int ch = 0; ch < 4; ch++) begin
      ea[ch*32 +: 32] = m_lat[0][ch][31:0];
      eb[ch*4 +: 4]   = m_lat[1][ch][3:0];
      eoa[ch]         = m_ovf[0][ch];
      eob[ch]         = m_ovf[1][ch];
    end
    chk("a_cnt_all", a_cnt_all, ea);
    chk("a_ovf", a_ovf, eoa);
    chk("a_valid", a_valid, m_valid[0]);
    chk("a_win_id", a_win_id, m_win[0]);
    chk("a_cnt_out", a_cnt_out, m_cout[0][31:0]);
    chk("b_cnt_all", b_cnt_all, eb);
    chk("b_ovf", b_ovf, eob);
    chk("b_valid", b_valid, m_valid[1]);
    chk("b_win_id", b_win_id, m_win[1]);
    chk("b_cnt_out", b_cnt_out, m_cout[1][3:0]);
`ifdef SPKCNT_DIFF_EN
    begin
      logic [65:0] eda;
      logic [9:0]  edb;
      longint      d;
      for (int k = 0; k < 2; k++) begin
        d = m_lat[0][2*k] - m_lat[0][2*k+1];
        eda[k*33 +: 33] = d[32:0];
        d = m_lat[1][2*k] - m_lat[1][2*k+1];
        edb[k*5 +: 5] = d[4:0];
      end
      chk("a_diff", a_diff, eda);
      chk("b_diff", b_diff, edb);
    end
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_cnt_all"}, a_cnt_all, '0);
    chk({tag, "_a_cnt_out"}, a_cnt_out, '0);
    chk({tag, "_a_ovf"}, a_ovf, '0);
    chk({tag, "_a_valid"}, a_valid, '0);
    chk({tag, "_a_win_id"}, a_win_id, '0);
    chk({tag, "_b_cnt_all"}, b_cnt_all, '0);
    chk({tag, "_b_cnt_out"}, b_cnt_out, '0);
    chk({tag, "_b_ovf"}, b_ovf, '0);
    chk({tag, "_b_valid"}, b_valid, '0);
    chk({tag, "_b_win_id"}, b_win_id, '0);
  endtask

  // Advance n clock edges; inputs change only at the falling edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk1);
      model_edge(spike, enable, window_tick, rd_sel);
      #1;
      check_all();
      @(negedge clk1);
    end
  endtask

  task automatic tick();
    window_tick = 1'b1;
    cyc(1);
    window_tick = 1'b0;
  endtask

  task automatic pulse_train(input logic [3:0] mask, input int np, input int hi, input int lo);
    for (int p = 0; p < np; p++) begin
      spike = spike | mask;
      cyc(hi);
      spike = spike & ~mask;
      cyc(lo);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    spike       = '0;
    enable      = 1'b1;
    window_tick = 1'b0;
    rd_sel      = '0;
    model_reset();
    @(posedge clk1);
    #1;
    chk_zero("reset");
    @(negedge clk1);
    reset_n = 1'b1;

    // Basic count: ch0 5 pulses, ch1 none, ch2 7 pulses, ch3 one pulse
    for (int c = 0; c < 40; c++) begin
      spike[0] = (c < 25) && (c % 5 < 2);
      spike[1] = 1'b0;
      spike[2] = (c < 35) && (c % 5 < 2);
      spike[3] = (c >= 3) && (c < 5);
      cyc(1);
    end
    spike = '0;
    cyc(5);
    tick();
    chk("basic_cnt_all", a_cnt_all, {32'd1, 32'd7, 32'd0, 32'd5});
    chk("basic_valid", a_valid, 1'b1);
    chk("basic_win_id", a_win_id, 16'd1);
    cyc(1);
    chk("basic_valid_drop", a_valid, 1'b0);
    rd_sel = 3'd2;
    cyc(1);
    chk("basic_cnt_out_ch2", a_cnt_out, 32'd7);

    // Boundary: edge detected on the tick cycle, then back-to-back tick
    cyc(15);
    spike[0] = 1'b1;
    cyc(2);
    spike[0] = 1'b0;
    window_tick = 1'b1;
    cyc(1);
    chk("bnd_closing", a_cnt_all[31:0], 32'd1);
    cyc(1);
    window_tick = 1'b0;
    chk("bnd_next_a", a_cnt_all[31:0], 32'd0);
    chk("bnd_next_b", b_cnt_all[3:0], 4'd1);
    chk("bnd_valid2", a_valid, 1'b1);
    cyc(1);
    chk("bnd_valid_end", a_valid, 1'b0);

    // Refractory: period 6 gives 3 of 6 on B, period 14 gives all 6
    cyc(15);
    pulse_train(4'b0010, 6, 2, 4);
    cyc(5);
    tick();
    chk("refr_b_short", b_cnt_all[7:4], 4'd3);
    chk("refr_a_short", a_cnt_all[63:32], 32'd6);
    pulse_train(4'b0010, 6, 2, 12);
    cyc(5);
    tick();
    chk("refr_b_long", b_cnt_all[7:4], 4'd6);

    // Saturation on the 4-bit instance
    cyc(15);
    pulse_train(4'b1000, 20, 2, 12);
    cyc(5);
    tick();
    chk("sat_b_lat3", b_cnt_all[15:12], 4'd15);
    chk("sat_b_ovf3", b_ovf[3], 1'b1);
    chk("sat_a_lat3", a_cnt_all[127:96], 32'd20);
    cyc(5);
    tick();
    chk("sat_b_empty", b_cnt_all[15:12], 4'd0);
    chk("sat_b_ovf_clr", b_ovf[3], 1'b0);

    // Enable low: spikes and tick are ignored
    enable = 1'b0;
    pulse_train(4'b1111, 3, 2, 3);
    tick();
    chk("en_novalid", a_valid, 1'b0);
    chk("en_win_hold", a_win_id, 16'd7);
    cyc(5);
    enable = 1'b1;
    cyc(2);
    tick();
    chk("en_nothing", a_cnt_all, 128'd0);

    // Asynchronous reset mid-window discards partial counts
    pulse_train(4'b0001, 3, 2, 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("midrst");
    model_reset();
    @(posedge clk1);
    @(posedge clk1);
    @(negedge clk1);
    reset_n = 1'b1;
    pulse_train(4'b0001, 2, 2, 3);
    cyc(3);
    tick();
    chk("postrst_lat0", a_cnt_all[31:0], 32'd2);
    chk("postrst_win", a_win_id, 16'd1);
    rd_sel = 3'd0;
    cyc(1);
    chk("rdsel_ch0", a_cnt_out, 32'd2);
    rd_sel = 3'd5;
    cyc(1);
    chk("rdsel_oob", a_cnt_out, 32'd0);

`ifdef SPKCNT_DIFF_EN
    // Pair difference: ch0=3, ch1=8 gives -5
    for (int c = 0; c < 40; c++) begin
      spike[0] = (c < 15) && (c % 5 < 2);
      spike[1] = (c % 5 < 2);
      cyc(1);
    end
    spike = '0;
    cyc(5);
    tick();
    chk("diff_pair0", a_diff[32:0], 33'h1_FFFF_FFFB);
`endif

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      spike       = 4'($urandom);
      enable      = ($urandom_range(0, 9) != 0);
      window_tick = ($urandom_range(0, 15) == 0);
      rd_sel      = 3'($urandom_range(0, 7));
      cyc(1);
    end
    spike       = '0;
    enable      = 1'b1;
    window_tick = 1'b0;
    cyc(5);
    tick();
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
